// File: rtl/ecc_154_enc_pipe_pkg.sv
// ecc_154_enc_pipe_pkg: shared widths, SECDED position mapping and injection modes
package ecc_154_enc_pipe_pkg;
  localparam int DEF_DATA_WIDTH = 154;
  localparam int DEF_PARITY_WIDTH = 9;
  localparam int HAM_WIDTH = 8;
  localparam logic [1:0] INJ_NONE = 2'd0;
  localparam logic [1:0] INJ_SINGLE = 2'd1;
  localparam logic [1:0] INJ_DOUBLE = 2'd2;
  function automatic int data_pos(input int i);
    int p;
    p = 2;
    for (int j = 0; j <= i; j++) begin
      p++;
      if ((p & (p - 1)) == 0) p++;
    end
    return p;
  endfunction
endpackage

// File: rtl/ecc_154_enc.sv
// ecc_154_enc: combinational SECDED parity generator (8 Hamming bits + overall parity)
module ecc_154_enc
  import ecc_154_enc_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PARITY_WIDTH = DEF_PARITY_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [PARITY_WIDTH-1:0] parity_out
);
  logic [HAM_WIDTH-1:0] term [DATA_WIDTH];
  logic [HAM_WIDTH-1:0] ham;
  // each set data bit contributes its codeword position to the Hamming syndrome
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_term
    localparam logic [HAM_WIDTH-1:0] POS = HAM_WIDTH'(data_pos(i));
    assign term[i] = data_in[i] ? POS : '0;
  end
  always_comb begin
    ham = '0;
    for (int i = 0; i < DATA_WIDTH; i++) ham = ham ^ term[i];
  end
  assign parity_out = PARITY_WIDTH'({(^data_in) ^ (^ham), ham});
endmodule

// File: rtl/ecc_154_enc_pipe.sv
// ecc_154_enc_pipe: registered SECDED encoder with lockstep fault detection and error injection
module ecc_154_enc_pipe
  import ecc_154_enc_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PARITY_WIDTH = DEF_PARITY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    bypass,
  input  logic                    ecc_fault_detc_en,
  input  logic                    inj_req,
  input  logic [1:0]              inj_mode,
  input  logic                    fdet_inj,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [7:0]              fault_cnt,
  input  logic                    fault_clr
);
  logic [PARITY_WIDTH-1:0] par0, par1;
  logic [DATA_WIDTH-1:0] flip;
  logic [1:0] mode;
  logic acc, mis, hit, arm;
  ecc_154_enc #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc0 (
    .data_in(data_in), .parity_out(par0));
  ecc_154_enc #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc1 (
    .data_in(data_in), .parity_out(par1));
  assign in_ready = ~out_valid | out_ready;
  assign acc = in_valid & in_ready;
  assign mis = (par0 != (par1 ^ PARITY_WIDTH'(fdet_inj))) & ecc_fault_detc_en & ~bypass;
  assign hit = acc & mis;
  // injection corrupts the data after encoding so the parity still describes the clean word
  assign flip = DATA_WIDTH'((arm && !bypass) ?
                  (mode == INJ_SINGLE ? 2'b01 : mode == INJ_DOUBLE ? 2'b11 : 2'b00) : 2'b00);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out <= '0;
      parity_out <= '0;
      ecc_fault <= 1'b0;
      arm <= 1'b0;
      mode <= INJ_NONE;
      fault_sticky <= 1'b0;
      fault_cnt <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        data_out <= data_in ^ flip;
        parity_out <= bypass ? '0 : par0;
        ecc_fault <= mis;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (inj_req) begin
        arm <= 1'b1;
        mode <= inj_mode;
      end else if (acc) begin
        arm <= 1'b0;
      end
      fault_sticky <= hit | (fault_sticky & ~fault_clr);
      fault_cnt <= fault_clr ? {7'd0, hit} :
                   (hit && fault_cnt != 8'hff) ? fault_cnt + 8'd1 : fault_cnt;
    end
  end
endmodule

// File: tb/tb_ecc_154_enc_pipe.sv
// tb_ecc_154_enc_pipe: randomized bench against a behavioural SECDED pipeline model
module tb_ecc_154_enc_pipe;
  localparam int DW = 154;
  localparam int PW = 9;
  logic clk, rst, in_valid, in_ready, bypass, en, inj_req, fdet_inj;
  logic out_valid, out_ready, ecc_fault, fault_sticky, fault_clr;
  logic [1:0] inj_mode;
  logic [DW-1:0] data_in, data_out;
  logic [PW-1:0] parity_out;
  logic [7:0] fault_cnt;
  int checks = 0;
  int errors = 0;
  int pos [DW];
  logic m_valid, m_fault, m_sticky, m_arm;
  logic [DW-1:0] m_data;
  logic [PW-1:0] m_par;
  logic [7:0] m_cnt;
  logic [1:0] m_mode;

  ecc_154_enc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .bypass(bypass), .ecc_fault_detc_en(en), .inj_req(inj_req), .inj_mode(inj_mode),
    .fdet_inj(fdet_inj), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .parity_out(parity_out), .ecc_fault(ecc_fault), .fault_sticky(fault_sticky),
    .fault_cnt(fault_cnt), .fault_clr(fault_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int q;
    q = 3;
    for (int i = 0; i < DW; i++) begin
      while ($countones(q) == 1) q++;
      pos[i] = q;
      q++;
    end
  end

  function automatic logic [PW-1:0] ref_par(input logic [DW-1:0] d);
    int h;
    h = 0;
    for (int i = 0; i < DW; i++) if (d[i]) h = h ^ pos[i];
    return {(^d) ^ (^h[7:0]), h[7:0]};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic acc, flt;
    logic [DW-1:0] fl;
    if (rst) begin
      m_valid = 0; m_data = '0; m_par = '0; m_fault = 0;
      m_sticky = 0; m_cnt = 0; m_arm = 0; m_mode = 0;
      return;
    end
    acc = in_valid && (!m_valid || out_ready);
    flt = acc && fdet_inj && en && !bypass;
    fl = '0;
    if (m_arm && !bypass && m_mode == 2'd1) fl = 1;
    if (m_arm && !bypass && m_mode == 2'd2) fl = 3;
    if (acc) begin
      m_valid = 1;
      m_data = data_in ^ fl;
      m_par = bypass ? '0 : ref_par(data_in);
      m_fault = fdet_inj && en && !bypass;
      m_arm = 0;
    end else if (out_ready) m_valid = 0;
    if (inj_req) begin m_arm = 1; m_mode = inj_mode; end
    if (fault_clr) begin
      m_sticky = flt;
      m_cnt = flt ? 8'd1 : 8'd0;
    end else if (flt) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("out_valid", 160'(out_valid), 160'(m_valid));
    chk("in_ready", 160'(in_ready), 160'(!m_valid || out_ready));
    chk("data_out", 160'(data_out), 160'(m_data));
    chk("parity_out", 160'(parity_out), 160'(m_par));
    chk("ecc_fault", 160'(ecc_fault), 160'(m_fault));
    chk("fault_sticky", 160'(fault_sticky), 160'(m_sticky));
    chk("fault_cnt", 160'(fault_cnt), 160'(m_cnt));
  end

  task automatic idle();
    in_valid = 0; data_in = '0; bypass = 0; en = 1; inj_req = 0; inj_mode = 0;
    fdet_inj = 0; out_ready = 1; fault_clr = 0; rst = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    in_valid = 1; data_in = d;
    tick();
    in_valid = 0;
  endtask

  initial begin
    logic [159:0] r;
    idle();
    rst = 1;
    tick(2);
    chk("rst_out_valid", 160'(out_valid), 0);
    chk("rst_data", 160'(data_out), 0);
    chk("rst_parity", 160'(parity_out), 0);
    chk("rst_cnt", 160'(fault_cnt), 0);
    chk("rst_sticky", 160'(fault_sticky), 0);
    rst = 0;
    tick();
    chk("ready_after_rst", 160'(in_ready), 1);
    beat('0);
    chk("zero_valid", 160'(out_valid), 1);
    chk("zero_parity", 160'(parity_out), 0);
    chk("zero_fault", 160'(ecc_fault), 0);
    beat(DW'(1));
    chk("one_parity", 160'(parity_out), 160'h103);
    chk("one_data", 160'(data_out), 1);
    inj_req = 1; inj_mode = 2'd1;
    tick();
    inj_req = 0;
    beat('0);
    chk("inj1_data", 160'(data_out), 1);
    chk("inj1_parity", 160'(parity_out), 0);
    beat('0);
    chk("inj_clean_data", 160'(data_out), 0);
    fdet_inj = 1;
    beat(DW'(5));
    chk("fdet_fault", 160'(ecc_fault), 1);
    chk("fdet_sticky", 160'(fault_sticky), 1);
    chk("fdet_cnt", 160'(fault_cnt), 1);
    en = 0;
    beat(DW'(5));
    chk("fdet_dis_fault", 160'(ecc_fault), 0);
    en = 1; fdet_inj = 0; fault_clr = 1;
    tick();
    fault_clr = 0;
    chk("clr_cnt", 160'(fault_cnt), 0);
    chk("clr_sticky", 160'(fault_sticky), 0);
    fdet_inj = 1; in_valid = 1;
    tick(300);
    in_valid = 0; fdet_inj = 0;
    chk("sat_cnt", 160'(fault_cnt), 255);
    beat(DW'(154'h2A5));
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(i + 100);
      tick();
    end
    chk("stall_ready", 160'(in_ready), 0);
    chk("stall_data", 160'(data_out), 160'h2A5);
    out_ready = 1;
    tick(2);
    in_valid = 0;
    tick();
    in_valid = 1; out_ready = 0; data_in = DW'(77);
    tick();
    in_valid = 0; rst = 1;
    tick();
    chk("rst_mid_valid", 160'(out_valid), 0);
    chk("rst_mid_data", 160'(data_out), 0);
    chk("rst_mid_fault", 160'(ecc_fault), 0);
    chk("rst_mid_sticky", 160'(fault_sticky), 0);
    rst = 0;
    tick();
    chk("rst_mid_ready", 160'(in_ready), 1);
    out_ready = 1;
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      data_in = r[DW-1:0];
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      bypass = $urandom_range(0, 7) == 0;
      en = $urandom_range(0, 3) != 0;
      fdet_inj = $urandom_range(0, 3) == 0;
      inj_req = $urandom_range(0, 7) == 0;
      inj_mode = 2'($urandom_range(0, 3));
      fault_clr = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 127) == 0;
      tick();
    end
    idle();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
